// File: rtl/booth_lfsr_seq_mul_if.sv
// Handshake and operand/result bus for booth_lfsr_seq_mul.
// The master drives requests and consumes products; the slave is the multiplier.
interface booth_lfsr_seq_mul_if #(
  parameter int N = 8
) ();
  logic           mode;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [2*N-1:0] product;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output mode, a_in, b_in, in_valid, out_ready,
    input  in_ready, op_a, op_b, product, out_valid
  );

  modport slave (
    input  mode, a_in, b_in, in_valid, out_ready,
    output in_ready, op_a, op_b, product, out_valid
  );
endinterface

// File: rtl/booth_lfsr_seq_mul.sv
// Sequential radix-4 Booth multiplier with operand LFSRs for self-test.
// Define BOOTH_MISR_EN to add the 'sig' output signature register over handed-off products.
module booth_lfsr_seq_mul #(
  parameter int           N    = 8,
  parameter logic [N-1:0] TAPS = 8'hB8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            seed_a,
  input  logic [N-1:0]            seed_b,
  booth_lfsr_seq_mul_if.slave     bus
`ifdef BOOTH_MISR_EN
  ,
  output logic [2*N-1:0]          sig
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int AW = 2*N + 2;
  localparam int HW = N + 2;
  localparam int CW = $clog2(N/2) + 1;

  state_t         state_q, state_d;
  logic [N-1:0]   lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [N-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [N:0]     mul_q, mul_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [2*N-1:0] product_q, product_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [HW-1:0]  a_ext, partial, hi_sum;
  logic [AW-1:0]  acc_shift;

  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] q);
    return {q[N-2:0], ^(q & TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [N-1:0] seed_load(input logic [N-1:0] s);
    return (s == '0) ? N'(1) : s;
  endfunction

  // mul_q[2:0] is the Booth window {b[2i+1], b[2i], b[2i-1]}; the sum lands in the top N+2 bits.
  always_comb begin
    a_ext = {{2{op_a_q[N-1]}}, op_a_q};
    case (mul_q[2:0])
      3'b001, 3'b010: partial = a_ext;
      3'b011:         partial = a_ext << 1;
      3'b100:         partial = -(a_ext << 1);
      3'b101, 3'b110: partial = -a_ext;
      default:        partial = '0;
    endcase
    hi_sum    = acc_q[AW-1:N] + partial;
    acc_shift = AW'($signed({hi_sum, acc_q[N-1:0]}) >>> 2);
  end

  always_comb begin
    state_d   = state_q;
    lfsr_a_d  = lfsr_a_q;
    lfsr_b_d  = lfsr_b_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    mul_d     = mul_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.mode) begin
            op_a_d = bus.a_in;
            op_b_d = bus.b_in;
          end else begin
            op_a_d   = lfsr_a_q;
            op_b_d   = lfsr_b_q;
            lfsr_a_d = lfsr_step(lfsr_a_q);
            lfsr_b_d = lfsr_step(lfsr_b_q);
          end
          mul_d   = {op_b_d, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_shift;
        mul_d = mul_q >> 2;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N/2 - 1)) begin
          product_d = acc_shift[2*N-1:0];
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_a_q  <= seed_load(seed_a);
      lfsr_b_q  <= seed_load(seed_b);
      op_a_q    <= '0;
      op_b_q    <= '0;
      mul_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_a_q  <= lfsr_a_d;
      lfsr_b_q  <= lfsr_b_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      mul_q     <= mul_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = product_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;

`ifdef BOOTH_MISR_EN
  logic [2*N-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (state_q == DONE && bus.out_ready) sig_d = {sig_q[2*N-2:0], sig_q[2*N-1]} ^ product_q;
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;
`endif

endmodule

// File: tb/tb_booth_lfsr_seq_mul.sv
// Self-checking bench for booth_lfsr_seq_mul: directed cases plus a random soak against a signed-multiply model.
// Define BOOTH_MISR_EN to also check the output signature.
module tb_booth_lfsr_seq_mul;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seed_a, seed_b;
`ifdef BOOTH_MISR_EN
  logic [15:0] sig;
  logic [15:0] sig_m;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0]  lfsr_a_m, lfsr_b_m;
  logic [7:0]  last_a, last_b;
  logic [15:0] last_p;

  booth_lfsr_seq_mul_if #(.N(8)) bus ();

  booth_lfsr_seq_mul #(.N(8), .TAPS(8'hB8)) dut (
    .clk    (clk),
    .rst    (rst),
    .seed_a (seed_a),
    .seed_b (seed_b),
    .bus    (bus)
`ifdef BOOTH_MISR_EN
    ,
    .sig    (sig)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsrNext(input logic [7:0] q);
    return {q[6:0], ^(q & 8'hB8)};
  endfunction

  function automatic logic [15:0] signedProduct(input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 16'(sa * sb);
  endfunction

  task automatic doReset(input logic [7:0] sa, input logic [7:0] sb);
    rst    = 1'b1;
    seed_a = sa;
    seed_b = sb;
    @(posedge clk); #1;
    rst = 1'b0;
    lfsr_a_m = (sa == 8'h00) ? 8'h01 : sa;
    lfsr_b_m = (sb == 8'h00) ? 8'h01 : sb;
`ifdef BOOTH_MISR_EN
    sig_m = 16'h0000;
`endif
  endtask

  // One full transaction starting in a slot #1 after a posedge with the block idle.
  task automatic applyStimulus(input logic m, input logic [7:0] a, input logic [7:0] b, input int stall);
    logic [7:0]  ea, eb;
    logic [15:0] ep;
    int          lat;
    checkOutput("in_ready_idle", bus.in_ready, 1'b1);
    bus.mode      = m;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    if (m) begin
      ea = a;
      eb = b;
    end else begin
      ea = lfsr_a_m;
      eb = lfsr_b_m;
      lfsr_a_m = lfsrNext(lfsr_a_m);
      lfsr_b_m = lfsrNext(lfsr_b_m);
    end
    ep = signedProduct(ea, eb);
    @(posedge clk); #1;
    bus.mode = 1'($urandom);
    bus.a_in = 8'($urandom);
    bus.b_in = 8'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      bus.in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'd5);
    checkOutput("product", bus.product, ep);
    checkOutput("op_a", bus.op_a, ea);
    checkOutput("op_b", bus.op_b, eb);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput("stall_product", bus.product, ep);
      checkOutput("stall_out_valid", bus.out_valid, 1'b1);
      checkOutput("stall_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput("handoff_out_valid", bus.out_valid, 1'b0);
    checkOutput("handoff_in_ready", bus.in_ready, 1'b1);
`ifdef BOOTH_MISR_EN
    sig_m = {sig_m[14:0], sig_m[15]} ^ ep;
    checkOutput("sig", sig, sig_m);
`endif
    last_a = bus.op_a;
    last_b = bus.op_b;
    last_p = bus.product;
  endtask

  initial begin
    bus.mode      = 1'b0;
    bus.a_in      = 8'h00;
    bus.b_in      = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;

    $display("[TB] reset state");
    doReset(8'h5A, 8'h3C);
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_product", bus.product, 16'h0000);
    checkOutput("rst_op_a", bus.op_a, 8'h00);
    checkOutput("rst_op_b", bus.op_b, 8'h00);
`ifdef BOOTH_MISR_EN
    checkOutput("rst_sig", sig, 16'h0000);
`endif

    $display("[TB] directed external operands");
    applyStimulus(1'b1, 8'h80, 8'h80, 0);
    checkOutput("min_squared", last_p, 16'h4000);
`ifdef BOOTH_MISR_EN
    checkOutput("sig_first", sig, 16'h4000);
`endif
    applyStimulus(1'b1, 8'h07, 8'hFD, 0);
    checkOutput("seven_x_m3", last_p, 16'hFFEB);
`ifdef BOOTH_MISR_EN
    checkOutput("sig_second", sig, 16'h7FEB);
`endif
    applyStimulus(1'b1, 8'h7F, 8'h80, 0);
    checkOutput("max_x_min", last_p, 16'hC080);
    applyStimulus(1'b1, 8'h00, 8'hA5, 0);
    checkOutput("zero_x_a5", last_p, 16'h0000);

    $display("[TB] LFSR operands and period");
    doReset(8'h01, 8'h00);
    applyStimulus(1'b0, 8'h00, 8'h00, 0);
    checkOutput("lfsr_first", last_p, 16'h0001);
    applyStimulus(1'b0, 8'h00, 8'h00, 0);
    checkOutput("lfsr_second", last_p, 16'h0004);
    for (int i = 0; i < 253; i++) applyStimulus(1'b0, 8'h00, 8'h00, 0);
    applyStimulus(1'b0, 8'h00, 8'h00, 0);
    checkOutput("lfsr_period", last_a, 8'h01);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 8'h00, 8'h00, 10);
    applyStimulus(1'b0, 8'h00, 8'h00, 0);

    $display("[TB] reset during RUN");
    doReset(8'hC3, 8'h2D);
    bus.mode     = 1'b1;
    bus.a_in     = 8'h55;
    bus.b_in     = 8'hAA;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_in_ready", bus.in_ready, 1'b1);
    checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
    checkOutput("midrst_product", bus.product, 16'h0000);
`ifdef BOOTH_MISR_EN
    sig_m = 16'h0000;
`endif
    applyStimulus(1'b0, 8'h00, 8'h00, 0);
    checkOutput("midrst_seed_a", last_a, 8'hC3);
    checkOutput("midrst_seed_b", last_b, 8'h2D);

    $display("[TB] random soak");
    for (int r = 0; r < 4; r++) begin
      doReset(8'($urandom), 8'($urandom));
      for (int i = 0; i < 50; i++)
        applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(3, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
